// File: rtl/mouse_bus_ctrl.sv
// mouse_bus_ctrl: takes status/DX/DY packets from the mouse master state machine,
// acknowledges each one, keeps an absolute cursor position clamped to the screen,
// and exposes buttons/X/Y/IRQ enable as CPU bus registers with an interrupt per packet.
module mouse_bus_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'hA0,
  parameter int         X_MAX     = 160,
  parameter int         Y_MAX     = 120
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] MOUSE_STATUS,
  input  logic [7:0] MOUSE_DX,
  input  logic [7:0] MOUSE_DY,
  input  logic       SEND_INTERRUPT,
  output logic       INTERRUPT_ACK,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA_IN,
  input  logic       BUS_WE,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_DATA_OE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK,
  output logic [7:0] MOUSE_X,
  output logic [7:0] MOUSE_Y
);

  localparam logic [7:0] X_LAST = 8'(X_MAX - 1);
  localparam logic [7:0] Y_LAST = 8'(Y_MAX - 1);
  localparam logic [7:0] X_HOME = 8'(X_MAX / 2);
  localparam logic [7:0] Y_HOME = 8'(Y_MAX / 2);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    CAPTURE = 4'b0010,
    UPDATE  = 4'b0100,
    NOTIFY  = 4'b1000
  } state_t;

  state_t state, state_nxt;

  // Packet delta as 9-bit two's complement; an overflowed axis contributes nothing.
  function automatic logic signed [8:0] pkt_delta(input logic sgn, input logic ovf,
                                                  input logic [7:0] mag);
    logic signed [8:0] d;
    d = $signed({sgn, mag});
    if (ovf) d = '0;
    return d;
  endfunction

  // Saturate a signed position sum into 0..last.
  function automatic logic [7:0] sat_pos(input logic signed [9:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v < 10'sd0)                    r = 8'd0;
    else if (v > $signed({2'b00, last})) r = last;
    else                               r = v[7:0];
    return r;
  endfunction

  // CPU writes may only place the cursor on screen.
  function automatic logic [7:0] sat_wr(input logic [7:0] d, input logic [7:0] last);
    return (d > last) ? last : d;
  endfunction

  logic              [2:0] btn_p1;
  logic signed       [8:0] dx_p1, dy_p1;
  logic              [7:0] x_pos, y_pos;
  logic              [2:0] buttons;
  logic                    irq_en;
  logic                    ack_d;

  logic              [7:0] bus_off;
  logic                    in_map, wr_x, wr_y, wr_en;
  logic signed       [9:0] x_sum, y_sum;
  logic                    unused_status_bit;

  // Offset arithmetic wraps, so a base near 8'hFF still decodes four registers.
  assign bus_off = BUS_ADDR - BASE_ADDR;
  assign in_map  = (bus_off[7:2] == 6'd0);
  assign wr_x    = BUS_WE && in_map && (bus_off[1:0] == 2'd1);
  assign wr_y    = BUS_WE && in_map && (bus_off[1:0] == 2'd2);
  assign wr_en   = BUS_WE && in_map && (bus_off[1:0] == 2'd3);

  // Y grows downward on screen, so a positive mouse dy moves the cursor up.
  assign x_sum = $signed({2'b00, x_pos}) + $signed({dx_p1[8], dx_p1});
  assign y_sum = $signed({2'b00, y_pos}) - $signed({dy_p1[8], dy_p1});

  assign unused_status_bit = MOUSE_STATUS[3];

  assign MOUSE_X = x_pos;
  assign MOUSE_Y = y_pos;

  // State register plus a one-cycle memory of the ACK pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      ack_d <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_d <= (state == CAPTURE);
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt           = state;
    INTERRUPT_ACK       = 1'b0;
    BUS_INTERRUPT_RAISE = 1'b0;
    case (state)
      IDLE: begin
        // The master may still be dropping SEND_INTERRUPT right after our ACK.
        if (SEND_INTERRUPT && !ack_d) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        INTERRUPT_ACK = 1'b1;
        state_nxt     = UPDATE;
      end
      UPDATE: begin
        state_nxt = irq_en ? NOTIFY : IDLE;
      end
      NOTIFY: begin
        BUS_INTERRUPT_RAISE = 1'b1;
        if (BUS_INTERRUPT_ACK || (wr_en && !BUS_DATA_IN[0])) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Packet capture: deltas are decoded once here so UPDATE only adds and clamps.
  always_ff @(posedge CLK) begin
    if (state == CAPTURE) begin
      btn_p1 <= MOUSE_STATUS[2:0];
      dx_p1  <= pkt_delta(MOUSE_STATUS[4], MOUSE_STATUS[6], MOUSE_DX);
      dy_p1  <= pkt_delta(MOUSE_STATUS[5], MOUSE_STATUS[7], MOUSE_DY);
    end
  end

  // Cursor, buttons and IRQ enable; a CPU write to an axis beats the packet delta.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_pos   <= X_HOME;
      y_pos   <= Y_HOME;
      buttons <= 3'd0;
      irq_en  <= 1'b1;
    end else begin
      if (wr_x)                 x_pos <= sat_wr(BUS_DATA_IN, X_LAST);
      else if (state == UPDATE) x_pos <= sat_pos(x_sum, X_LAST);
      if (wr_y)                 y_pos <= sat_wr(BUS_DATA_IN, Y_LAST);
      else if (state == UPDATE) y_pos <= sat_pos(y_sum, Y_LAST);
      if (state == UPDATE)      buttons <= btn_p1;
      if (wr_en)                irq_en <= BUS_DATA_IN[0];
    end
  end

  // Registered read port: one cycle of OE per read-cycle address in the map.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      BUS_DATA_OUT <= 8'd0;
      BUS_DATA_OE  <= 1'b0;
    end else if (!BUS_WE && in_map) begin
      BUS_DATA_OE <= 1'b1;
      case (bus_off[1:0])
        2'd0:    BUS_DATA_OUT <= {5'b0, buttons};
        2'd1:    BUS_DATA_OUT <= x_pos;
        2'd2:    BUS_DATA_OUT <= y_pos;
        default: BUS_DATA_OUT <= {7'b0, irq_en};
      endcase
    end else begin
      BUS_DATA_OUT <= 8'd0;
      BUS_DATA_OE  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mouse_bus_ctrl.sv
// tb_mouse_bus_ctrl: vector table, directed handshake corner cases and a
// randomized packet run against an integer cursor model.
module tb_mouse_bus_ctrl;

  localparam logic [7:0] BASE  = 8'hA0;
  localparam int         X_MAX = 160;
  localparam int         Y_MAX = 120;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic       INTERRUPT_ACK;
  logic [7:0] BUS_ADDR, BUS_DATA_IN;
  logic       BUS_WE;
  logic [7:0] BUS_DATA_OUT;
  logic       BUS_DATA_OE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;
  logic [7:0] MOUSE_X, MOUSE_Y;

  mouse_bus_ctrl #(.BASE_ADDR(BASE), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .CLK(CLK), .RESET(RESET),
    .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY),
    .SEND_INTERRUPT(SEND_INTERRUPT), .INTERRUPT_ACK(INTERRUPT_ACK),
    .BUS_ADDR(BUS_ADDR), .BUS_DATA_IN(BUS_DATA_IN), .BUS_WE(BUS_WE),
    .BUS_DATA_OUT(BUS_DATA_OUT), .BUS_DATA_OE(BUS_DATA_OE),
    .BUS_INTERRUPT_RAISE(BUS_INTERRUPT_RAISE), .BUS_INTERRUPT_ACK(BUS_INTERRUPT_ACK),
    .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int ack_cnt = 0;
  int mx, my, mb;

  always @(negedge CLK) if (INTERRUPT_ACK === 1'b1) ack_cnt <= ack_cnt + 1;

  typedef struct {
    logic [7:0] s, dx, dy;
    logic [7:0] ex, ey;
    logic [2:0] eb;
  } vec_t;
  vec_t tbl[9];

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1; SEND_INTERRUPT = 1'b0; BUS_WE = 1'b0; BUS_ADDR = 8'h00;
    BUS_INTERRUPT_ACK = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    mx = 80; my = 60; mb = 0;
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [7:0] v);
    BUS_ADDR = BASE + off; BUS_DATA_IN = v; BUS_WE = 1'b1;
    tick();
    BUS_WE = 1'b0; BUS_ADDR = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [7:0] d, output logic oe);
    BUS_ADDR = BASE + off; BUS_WE = 1'b0;
    tick();
    d = BUS_DATA_OUT; oe = BUS_DATA_OE;
    BUS_ADDR = 8'h00;
    tick();
    chk("oe_one_cycle", BUS_DATA_OE, 0);
  endtask

  task automatic present(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
    MOUSE_STATUS = s; MOUSE_DX = dx; MOUSE_DY = dy; SEND_INTERRUPT = 1'b1;
  endtask

  task automatic wait_ack(output bit ok);
    int cyc;
    cyc = 0; ok = 0;
    while (cyc < 10) begin
      tick(); cyc++;
      if (INTERRUPT_ACK) begin ok = 1; break; end
    end
    chk("ack_seen", ok, 1);
  endtask

  task automatic wait_raise(output bit ok);
    int cyc;
    cyc = 0;
    while (!BUS_INTERRUPT_RAISE && cyc < 6) begin tick(); cyc++; end
    ok = BUS_INTERRUPT_RAISE;
    chk("raise_seen", ok, 1);
  endtask

  task automatic cpu_ack();
    BUS_INTERRUPT_ACK = 1'b1;
    tick();
    BUS_INTERRUPT_ACK = 1'b0;
    chk("raise_drop", BUS_INTERRUPT_RAISE, 0);
  endtask

  task automatic run_packet(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy,
                            input bit exp_irq);
    int base;
    bit ok, seen;
    base = ack_cnt;
    present(s, dx, dy);
    wait_ack(ok);
    SEND_INTERRUPT = 1'b0;
    if (exp_irq) begin
      wait_raise(ok);
      tick();
      chk("raise_hold", BUS_INTERRUPT_RAISE, 1);
      cpu_ack();
    end else begin
      seen = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (BUS_INTERRUPT_RAISE) seen = 1; end
      chk("no_raise", seen, 0);
    end
    chk("ack_count", ack_cnt - base, 1);
  endtask

  function automatic int clampi(input int v, input int max);
    if (v < 0) return 0;
    if (v > max - 1) return max - 1;
    return v;
  endfunction

  task automatic model_packet(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
    int ddx, ddy;
    ddx = s[6] ? 0 : (s[4] ? int'(dx) - 256 : int'(dx));
    ddy = s[7] ? 0 : (s[5] ? int'(dy) - 256 : int'(dy));
    mx = clampi(mx + ddx, X_MAX);
    my = clampi(my - ddy, Y_MAX);
    mb = int'(s[2:0]);
  endtask

  initial begin
    logic [7:0] d;
    logic       oe;
    logic [7:0] s, dx, dy, v;
    int base;
    bit ok;

    tbl[0] = '{8'h01, 8'h05, 8'h03, 8'd85,  8'd57,  3'd1};
    tbl[1] = '{8'h10, 8'h00, 8'h00, 8'd0,   8'd57,  3'd0};
    tbl[2] = '{8'h00, 8'hFF, 8'h00, 8'd159, 8'd57,  3'd0};
    tbl[3] = '{8'h00, 8'hFF, 8'h00, 8'd159, 8'd57,  3'd0};
    tbl[4] = '{8'h42, 8'h20, 8'h02, 8'd159, 8'd55,  3'd2};
    tbl[5] = '{8'h20, 8'h00, 8'h00, 8'd159, 8'd119, 3'd0};
    tbl[6] = '{8'h97, 8'hF6, 8'h50, 8'd149, 8'd119, 3'd7};
    tbl[7] = '{8'h00, 8'h0A, 8'h64, 8'd159, 8'd19,  3'd0};
    tbl[8] = '{8'h00, 8'h00, 8'h20, 8'd159, 8'd0,   3'd0};

    MOUSE_STATUS = 8'h00; MOUSE_DX = 8'h00; MOUSE_DY = 8'h00; BUS_DATA_IN = 8'h00;
    do_reset();

    // Reset state and first reads.
    chk("rst_x", MOUSE_X, 8'd80);
    chk("rst_y", MOUSE_Y, 8'd60);
    chk("rst_raise", BUS_INTERRUPT_RAISE, 0);
    chk("rst_ack", INTERRUPT_ACK, 0);
    chk("rst_oe", BUS_DATA_OE, 0);
    chk("rst_dout", BUS_DATA_OUT, 0);
    bus_read(8'd1, d, oe);
    chk("read_x_data", d, 8'h50);
    chk("read_x_oe", oe, 1);
    bus_read(8'd3, d, oe);
    chk("read_irqen", d, 8'h01);
    bus_read(8'd4, d, oe);
    chk("unmapped_oe", oe, 0);

    // Exact latency of one packet.
    base = ack_cnt;
    present(8'h01, 8'h05, 8'h03);
    tick();
    chk("lat_ack", INTERRUPT_ACK, 1);
    chk("lat_x_old", MOUSE_X, 8'd80);
    SEND_INTERRUPT = 1'b0;
    tick();
    chk("lat_ack_once", INTERRUPT_ACK, 0);
    chk("lat_raise_early", BUS_INTERRUPT_RAISE, 0);
    tick();
    chk("lat_x", MOUSE_X, 8'd85);
    chk("lat_y", MOUSE_Y, 8'd57);
    chk("lat_raise", BUS_INTERRUPT_RAISE, 1);
    tick();
    chk("lat_raise_hold", BUS_INTERRUPT_RAISE, 1);
    cpu_ack();
    tick();
    chk("lat_raise_low", BUS_INTERRUPT_RAISE, 0);
    chk("lat_ack_total", ack_cnt - base, 1);
    bus_read(8'd0, d, oe);
    chk("lat_btn", d, 8'h01);

    // Vector table, chained from the reset position.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_packet(tbl[i].s, tbl[i].dx, tbl[i].dy, 1'b1);
      chk("tbl_x", MOUSE_X, tbl[i].ex);
      chk("tbl_y", MOUSE_Y, tbl[i].ey);
      bus_read(8'd0, d, oe);
      chk("tbl_btn", d, {5'b0, tbl[i].eb});
    end

    // Clamp at the right edge from the centre, twice.
    do_reset();
    run_packet(8'h00, 8'hFF, 8'h00, 1'b1);
    chk("clamp_r1", MOUSE_X, 8'd159);
    run_packet(8'h00, 8'hFF, 8'h00, 1'b1);
    chk("clamp_r2", MOUSE_X, 8'd159);

    // Back-to-back: second packet waits out NOTIFY.
    base = ack_cnt;
    present(8'h10, 8'hF6, 8'h00);
    wait_ack(ok);
    SEND_INTERRUPT = 1'b0;
    wait_raise(ok);
    present(8'h10, 8'hF6, 8'h00);
    tick(); tick(); tick();
    chk("b2b_hold_raise", BUS_INTERRUPT_RAISE, 1);
    chk("b2b_hold_acks", ack_cnt - base, 1);
    chk("b2b_x_first", MOUSE_X, 8'd149);
    cpu_ack();
    wait_ack(ok);
    SEND_INTERRUPT = 1'b0;
    wait_raise(ok);
    cpu_ack();
    tick(); tick();
    chk("b2b_acks", ack_cnt - base, 2);
    chk("b2b_x", MOUSE_X, 8'd139);

    // CPU write to X collides with UPDATE: write wins on X, Y still moves.
    present(8'h00, 8'h05, 8'h05);
    wait_ack(ok);
    SEND_INTERRUPT = 1'b0;
    tick();
    BUS_ADDR = BASE + 8'd1; BUS_DATA_IN = 8'hC8; BUS_WE = 1'b1;
    tick();
    BUS_WE = 1'b0; BUS_ADDR = 8'h00;
    chk("coll_x", MOUSE_X, 8'd159);
    chk("coll_y", MOUSE_Y, 8'd55);
    wait_raise(ok);
    cpu_ack();

    // Register writes.
    bus_write(8'd1, 8'h30);
    bus_read(8'd1, d, oe);
    chk("wr_x", d, 8'h30);
    bus_write(8'd2, 8'hFF);
    chk("wr_y_clamp", MOUSE_Y, 8'd119);
    bus_write(8'd0, 8'h55);
    bus_read(8'd0, d, oe);
    chk("wr_btn_ro", d, 8'h00);

    // Clearing IRQ_EN while in NOTIFY drops RAISE, then packets raise nothing.
    present(8'h00, 8'h00, 8'h00);
    wait_ack(ok);
    SEND_INTERRUPT = 1'b0;
    wait_raise(ok);
    bus_write(8'd3, 8'h00);
    chk("irqen_drop", BUS_INTERRUPT_RAISE, 0);
    tick();
    chk("irqen_stay", BUS_INTERRUPT_RAISE, 0);
    bus_read(8'd3, d, oe);
    chk("irqen_read", d, 8'h00);
    run_packet(8'h01, 8'h00, 8'h00, 1'b0);
    bus_read(8'd0, d, oe);
    chk("noirq_btn", d, 8'h01);
    bus_write(8'd3, 8'h01);

    // Reset while in UPDATE abandons the packet.
    present(8'h00, 8'h10, 8'h00);
    wait_ack(ok);
    SEND_INTERRUPT = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rstupd_x", MOUSE_X, 8'd80);
    chk("rstupd_y", MOUSE_Y, 8'd60);
    base = ack_cnt;
    for (int i = 0; i < 4; i++) tick();
    chk("rstupd_noack", ack_cnt - base, 0);
    chk("rstupd_noraise", BUS_INTERRUPT_RAISE, 0);
    chk("rstupd_x_hold", MOUSE_X, 8'd80);

    // Randomized packets and occasional CPU writes against the cursor model.
    do_reset();
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = 8'($urandom_range(0, 255));
        bus_write(8'd1, v);
        mx = clampi(int'(v), X_MAX);
      end
      s  = 8'($urandom);
      dx = 8'($urandom);
      dy = 8'($urandom);
      run_packet(s, dx, dy, 1'b1);
      model_packet(s, dx, dy);
      chk("rnd_x", MOUSE_X, 32'(mx));
      chk("rnd_y", MOUSE_Y, 32'(my));
      bus_read(8'd0, d, oe);
      chk("rnd_btn", d, 32'(mb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
